platform_rate_sched: RTL and testbench

Scheduler that owns the platform scroll rate for Doodle Fall. It issues single-cycle platform_tick enables at a programmable period, tightens that period on a fixed ramp interval (difficulty), and runs the power-block sequence: a timed slowdown followed by a stepwise recovery to the saved rate. It sits between the game FSM (run/pause/power inputs) and the platform-motion logic, replacing free-running divided clocks with clk-domain enables.

---
 rtl/platform_rate_sched.sv | 79 +++++++
 tb/tb_platform_rate_sched.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/platform_rate_sched.sv
// platform_rate_sched: issues platform_tick enables at a programmable period with difficulty ramp
// and a power-block slowdown followed by stepwise recovery to the saved rate.
module platform_rate_sched #(
  parameter int unsigned START_PERIOD = 500000,
  parameter int unsigned MIN_PERIOD   = 200000,
  parameter int unsigned STEP         = 1000,
  parameter int unsigned RAMP_CYCLES  = 5000000,
  parameter int unsigned POWER_PERIOD = 500000,
  parameter int unsigned POWER_CYCLES = 150000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        pause,
  input  logic        power_signal,
  output logic        platform_tick,
  output logic [31:0] period,
  output logic [1:0]  state,
  output logic        power_active
);
  typedef enum logic [1:0] {IDLE, RUN, POWER, RECOVER} st_t;
  st_t st;
  logic [31:0] saved, tick_cnt, ramp_cnt, pwr_cnt, slow_period;
  logic tick_hit, ramp_hit;
  // >= lets a period that shrank below the live count fire on the next cycle
  assign tick_hit = tick_cnt >= period - 32'd1;
  assign ramp_hit = ramp_cnt == RAMP_CYCLES - 1;
  assign slow_period = period > POWER_PERIOD ? period : POWER_PERIOD;
  assign state = st;
  assign power_active = st == POWER || st == RECOVER;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st <= IDLE;
      period <= START_PERIOD;
      saved <= START_PERIOD;
      tick_cnt <= '0;
      ramp_cnt <= '0;
      pwr_cnt <= '0;
      platform_tick <= 1'b0;
    end else if (!run || st == IDLE) begin
      st <= run ? RUN : IDLE;
      period <= run ? period : START_PERIOD;
      tick_cnt <= '0;
      ramp_cnt <= '0;
      pwr_cnt <= '0;
      platform_tick <= 1'b0;
    end else if (pause) begin
      platform_tick <= 1'b0;
    end else begin
      platform_tick <= tick_hit;
      tick_cnt <= tick_hit ? '0 : tick_cnt + 32'd1;
      ramp_cnt <= ramp_hit ? '0 : ramp_cnt + 32'd1;
      if (st == RUN) begin
        if (power_signal) begin
          saved <= period;
          period <= slow_period;
          pwr_cnt <= '0;
          st <= POWER;
        end else if (ramp_hit)
          period <= period >= MIN_PERIOD + STEP ? period - STEP : MIN_PERIOD;
      end else if (st == POWER) begin
        if (power_signal)
          pwr_cnt <= '0;
        else if (pwr_cnt == POWER_CYCLES - 1) begin
          pwr_cnt <= '0;
          st <= RECOVER;
        end else
          pwr_cnt <= pwr_cnt + 32'd1;
      end else if (power_signal) begin
        period <= slow_period;
        pwr_cnt <= '0;
        st <= POWER;
      end else if (ramp_hit) begin
        // period - STEP <= saved, rearranged so the subtraction can never wrap
        period <= period <= saved + STEP ? saved : period - STEP;
        st <= period <= saved + STEP ? RUN : RECOVER;
      end
    end
endmodule

// File: tb/tb_platform_rate_sched.sv
// tb_platform_rate_sched: directed checks of ticks, ramp, power/recover, pause and abort.
module tb_platform_rate_sched;
  logic clk = 1'b0, rst = 1'b0, run = 1'b0, pause = 1'b0, power_signal = 1'b0;
  logic platform_tick, power_active;
  logic [31:0] period;
  logic [1:0] state;
  int cyc = 0, entry = 0, n_tests = 0, n_fail = 0;
  int tq[$];

  platform_rate_sched #(
    .START_PERIOD(20), .MIN_PERIOD(8), .STEP(4), .RAMP_CYCLES(50),
    .POWER_PERIOD(30), .POWER_CYCLES(100)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .pause(pause), .power_signal(power_signal),
    .platform_tick(platform_tick), .period(period), .state(state), .power_active(power_active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    if (platform_tick) tq.push_back(cyc - entry);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int tq_at(input int i);
    return tq.size() > i ? tq[i] : -1;
  endfunction

  task automatic at(input int r);
    while (cyc - entry < r) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic restart();
    run = 1'b0;
    @(posedge clk);
    #1;
    run = 1'b1;
    @(posedge clk);
    #1;
    entry = cyc;
    tq.delete();
  endtask

  task automatic power_at(input int r);
    at(r - 1);
    power_signal = 1'b1;
    at(r);
    power_signal = 1'b0;
  endtask

  int exp_ticks[11] = '{20, 40, 56, 72, 88, 101, 113, 125, 137, 149, 157};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", state, 0);
    check("rst_period", period, 20);
    check("rst_tick", platform_tick, 0);
    check("rst_pa", power_active, 0);
    rst = 1'b1;
    run = 1'b1;
    @(posedge clk);
    #1;
    entry = cyc;
    tq.delete();
    check("run_state", state, 1);
    at(49); check("ramp_49", period, 20);
    at(50); check("ramp_50", period, 16);
    at(100); check("ramp_100", period, 12);
    at(150); check("ramp_150", period, 8);
    at(200); check("ramp_200_clamp", period, 8);
    for (int i = 0; i < 11; i++) check($sformatf("tick_%0d", i), tq_at(i), exp_ticks[i]);
    check("tick_count_200", tq.size(), 16);

    restart();
    power_at(120);
    check("pw_state", state, 2);
    check("pw_period", period, 30);
    check("pw_active", power_active, 1);
    at(219); check("pw_219", state, 2);
    at(220); check("rec_220", state, 3);
    at(250); check("rec_250", period, 26);
    at(400); check("rec_400_p", period, 14);
    check("rec_400_s", state, 3);
    at(450); check("rec_450_p", period, 12);
    check("rec_450_s", state, 1);
    check("rec_450_pa", power_active, 0);

    restart();
    power_at(120);
    power_at(180);
    at(279); check("ext_279", state, 2);
    at(280); check("ext_280", state, 3);
    at(300); check("ext_300", period, 26);
    at(350); check("ext_350", period, 22);
    power_at(370);
    check("rtr_state", state, 2);
    check("rtr_period", period, 30);
    at(469); check("rtr_469", state, 2);
    at(470); check("rtr_470", state, 3);
    at(500); check("rtr_500", period, 26);
    at(700); check("rtr_700_p", period, 12);
    check("rtr_700_s", state, 1);
    power_at(750);
    check("coin_state", state, 2);
    check("coin_period", period, 30);
    at(850); check("coin_850", state, 3);
    at(1100); check("coin_1100_p", period, 12);
    check("coin_1100_s", state, 1);

    restart();
    at(45);
    pause = 1'b1;
    power_signal = 1'b1;
    at(82);
    check("pause_state", state, 1);
    check("pause_period", period, 20);
    check("pause_pa", power_active, 0);
    pause = 1'b0;
    power_signal = 1'b0;
    at(86); check("pause_ramp_86", period, 20);
    at(87); check("pause_ramp_87", period, 16);
    at(95);
    check("pause_tick_n", tq.size(), 3);
    check("pause_tick_1", tq_at(1), 40);
    check("pause_tick_2", tq_at(2), 93);

    restart();
    power_at(120);
    at(149);
    run = 1'b0;
    at(150);
    tq.delete();
    check("abort_state", state, 0);
    check("abort_period", period, 20);
    check("abort_pa", power_active, 0);
    check("abort_tick", platform_tick, 0);
    at(180);
    check("idle_ticks", tq.size(), 0);
    run = 1'b1;
    @(posedge clk);
    #1;
    entry = cyc;
    tq.delete();
    power_at(120);
    at(225);
    check("pre_rst_state", state, 3);
    #2 rst = 1'b0;
    #1;
    check("arst_state", state, 0);
    check("arst_period", period, 20);
    check("arst_pa", power_active, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    entry = cyc;
    tq.delete();
    check("rerun_state", state, 1);
    at(25);
    check("rerun_tick_n", tq.size(), 1);
    check("rerun_tick_0", tq_at(0), 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
